// File: rtl/fn_scan_ctrl.sv
// Truth-table scanner for a 4-input function block: walks all 16 vectors,
// captures f, counts ones and compares against a golden table.
module fn_scan_ctrl #(
  parameter logic [15:0] EXPECTED = 16'h73F0,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones,
  output logic        match,
  output logic        fail_valid,
  output logic [3:0]  first_fail
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  ones_q, ones_d;
  logic        match_q, match_d;
  logic        fv_q, fv_d;
  logic [3:0]  ff_q, ff_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
      match_q <= 1'b0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      match_q <= match_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start && !abort) state_d = S_SETTLE;
      S_SETTLE:
        if (abort) state_d = S_IDLE;
        else if (cnt_q == 4'd1) state_d = S_SAMPLE;
      S_SAMPLE:
        if (abort) state_d = S_IDLE;
        else if (idx_q == 4'd15) state_d = S_DONE;
        else state_d = S_SETTLE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    table_d = table_q;
    ones_d  = ones_q;
    match_d = match_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    busy_d  = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d  = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          table_d = '0;
          ones_d  = '0;
          match_d = 1'b0;
          fv_d    = 1'b0;
          ff_d    = '0;
          idx_d   = '0;
          abcd_d  = '0;
          cnt_d   = SETTLE_CNT;
        end
      end
      S_SETTLE: begin
        if (abort) abcd_d = '0;
        else if (cnt_q != 4'd1) cnt_d = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        if (abort) begin
          abcd_d = '0;
        end else begin
          table_d[idx_q] = f_in;
          ones_d = ones_q + {4'd0, f_in};
          if ((f_in != EXPECTED[idx_q]) && !fv_q) begin
            fv_d = 1'b1;
            ff_d = idx_q;
          end
          // match must see the bit captured on this very edge
          if (idx_q == 4'd15) begin
            match_d = (table_d == EXPECTED);
            abcd_d  = '0;
          end else begin
            idx_d  = idx_q + 4'd1;
            abcd_d = idx_q + 4'd1;
            cnt_d  = SETTLE_CNT;
          end
        end
      end
      S_DONE:
        abcd_d = '0;
      default: ;
    endcase
  end

  assign abcd       = abcd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign ones       = ones_q;
  assign match      = match_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_fn_scan_ctrl.sv
// Bench for fn_scan_ctrl: directed scans with a golden-result scoreboard,
// plus a SETTLE=3 instance fed a glitching function output.
module tb_fn_scan_ctrl;

  localparam logic [15:0] GOLD = 16'h73F0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0;
  logic [15:0] fn_tt = GOLD;
  logic        f_in1, f_in2;
  logic [3:0]  abcd1, abcd2, ff1, ff2;
  logic        busy1, busy2, done1, done2;
  logic [15:0] table1, table2;
  logic [4:0]  ones1, ones2;
  logic        match1, match2, fv1, fv2;
  logic [1:0]  ph = 2'd0;
  int          ndone1 = 0, ndone2 = 0;
  int          ntotal = 0, npass = 0;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic        m;
    logic        fv;
    logic [3:0]  ff;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign f_in1 = fn_tt[abcd1];
  assign f_in2 = (ph == 2'd3) ? fn_tt[abcd2] : ~fn_tt[abcd2];

  always @(posedge clk) begin
    ph <= busy2 ? ph + 2'd1 : 2'd0;
    if (done1) ndone1 <= ndone1 + 1;
    if (done2) ndone2 <= ndone2 + 1;
  end

  fn_scan_ctrl #(.EXPECTED(GOLD), .SETTLE(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .abort(abort1),
    .f_in(f_in1), .abcd(abcd1), .busy(busy1), .done(done1),
    .table_out(table1), .ones(ones1), .match(match1),
    .fail_valid(fv1), .first_fail(ff1)
  );

  fn_scan_ctrl #(.EXPECTED(GOLD), .SETTLE(3)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0),
    .f_in(f_in2), .abcd(abcd2), .busy(busy2), .done(done2),
    .table_out(table2), .ones(ones2), .match(match2),
    .fail_valid(fv2), .first_fail(ff2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [15:0] tt, input int settle);
    exp_t e;
    logic [15:0] d;
    d = tt ^ GOLD;
    e.tbl  = tt;
    e.ones = 5'($countones(tt));
    e.m    = (d == 16'h0);
    e.fv   = |d;
    e.ff   = 4'd0;
    for (int i = 15; i >= 0; i--) if (d[i]) e.ff = 4'(i);
    e.lat  = 16 * (settle + 1);
    return e;
  endfunction

  function automatic logic [63:0] pack1();
    return {31'd0, abcd1, busy1, done1, table1, ones1, match1, fv1, ff1};
  endfunction

  task automatic scan1(input logic [15:0] tt, input bit repulse,
                       input string tag);
    exp_t e;
    int dk, nd0, bad;
    logic [15:0] t_s;
    logic [4:0]  o_s;
    logic        m_s, fv_s;
    logic [3:0]  ff_s;
    fn_tt = tt;
    sb.push_back(model(tt, 1));
    nd0 = ndone1; dk = -1; bad = 0;
    t_s = '0; o_s = '0; m_s = 0; fv_s = 0; ff_s = '0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dk < 0 && done1) begin
        dk = k;
        t_s = table1; o_s = ones1; m_s = match1;
        fv_s = fv1; ff_s = ff1;
      end else if (dk < 0 && (abcd1 !== 4'(k / 2) || busy1 !== 1'b1)) begin
        bad++;
      end
      start1 = repulse && (k == 5 || k == 20 || k == dk);
    end
    start1 = 1'b0;
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(dk), 64'(e.lat));
    chk({tag, "_abcd_seq"}, 64'(bad), 64'd0);
    chk({tag, "_table"}, 64'(t_s), 64'(e.tbl));
    chk({tag, "_ones"}, 64'(o_s), 64'(e.ones));
    chk({tag, "_match"}, 64'(m_s), 64'(e.m));
    chk({tag, "_fail_valid"}, 64'(fv_s), 64'(e.fv));
    chk({tag, "_first_fail"}, 64'(ff_s), 64'(e.ff));
    chk({tag, "_done_count"}, 64'(ndone1 - nd0), 64'd1);
    chk({tag, "_idle_after"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    int nd0, dk, bad;
    exp_t e;
    #1;
    chk("reset_outputs", pack1(), 64'd0);
    @(negedge clk); rstn = 1'b1;

    scan1(GOLD, 1'b0, "good");
    scan1(16'h33F0, 1'b0, "bad14");
    scan1(16'h33F4, 1'b0, "bad2_14");
    scan1(GOLD, 1'b1, "repulse");

    // abort while vector 5 is settling
    fn_tt = GOLD;
    nd0 = ndone1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_at_vec5", {abcd1, busy1}, {4'd5, 1'b1});
    abort1 = 1'b1;
    @(negedge clk); abort1 = 1'b0;
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_table", 64'(table1), 64'h0010);
    chk("abort_ones", 64'(ones1), 64'd1);
    chk("abort_match", 64'(match1), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(ndone1 - nd0), 64'd0);
    scan1(GOLD, 1'b0, "after_abort");

    // asynchronous reset in the middle of a scan
    fn_tt = GOLD;
    nd0 = ndone1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk); #3 rstn = 1'b0;
    #1 chk("async_reset", pack1(), 64'd0);
    @(negedge clk); rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("reset_idle", {busy1, 32'(ndone1 - nd0)}, 33'd0);

    // SETTLE=3 with f_in wrong in all but the last cycle of each vector
    fn_tt = GOLD;
    sb.push_back(model(GOLD, 3));
    nd0 = ndone2; dk = -1; bad = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (dk < 0 && done2) begin
        dk = k;
        e = sb.pop_front();
        chk("s3_table", 64'(table2), 64'(e.tbl));
        chk("s3_ones", 64'(ones2), 64'(e.ones));
        chk("s3_match", {match2, fv2}, {e.m, e.fv});
        chk("s3_latency", 64'(dk), 64'(e.lat));
      end else if (dk < 0 && abcd2 !== 4'(k / 4)) begin
        bad++;
      end
    end
    chk("s3_done_seen", 64'(dk > 0), 64'd1);
    chk("s3_abcd_seq", 64'(bad), 64'd0);
    chk("s3_done_count", 64'(ndone2 - nd0), 64'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/fn_scan_ctrl.md
Name: fn_scan_ctrl

Overview:
Sequencer that exhaustively exercises a 4-input combinational function block built around an 8:1 mux, where a,b,c select and d is a data input.
- On start it drives all 16 input vectors in order and samples the function output for each.
- It assembles the 16-bit truth table and counts the ones.
- It compares the table against an expected pattern and reports pass/fail with the first failing minterm.
- It sits between the lab test harness and the function block under test.

Parameters:
EXPECTED, 16'h73F0, golden truth table; bit i = f for minterm i, where i = {a,b,c,d} with a as MSB.
SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  begin a scan; honoured only in IDLE
abort  input  1  cancel an in-progress scan
f_in  input  1  output of the function block under test
abcd  output  4  vector driven to the block; abcd[3]=a, abcd[0]=d
busy  output  1  scan in progress
done  output  1  one-cycle pulse when a scan completes
table_out  output  16  captured truth table
ones  output  5  number of 1s in table_out (0..16)
match  output  1  table_out == EXPECTED, valid from done onward
fail_valid  output  1  at least one minterm mismatched
first_fail  output  4  lowest mismatching minterm index

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE. abcd=0, busy=0, done=0, table_out=0, ones=0, match=0, fail_valid=0, first_fail=0. Reset mid-scan aborts immediately, with no done pulse.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1 (and abort=0): clear table_out, ones, match, fail_valid, first_fail; set idx=0, abcd=0, settle counter cnt=SETTLE; go to SETTLE.
  - Otherwise hold all results.
- SETTLE:
  - busy=1, abcd=idx.
  - If cnt==1, go to SAMPLE; else cnt decrements.
- SAMPLE:
  - busy=1.
  - table_out[idx] <= f_in; ones <= ones + f_in.
  - If f_in != EXPECTED[idx] and fail_valid==0: fail_valid <= 1, first_fail <= idx.
  - If idx==15, go to DONE. Else idx <= idx+1, abcd <= idx+1, cnt <= SETTLE, go to SETTLE.
- DONE:
  - busy=0, done=1 for exactly this cycle, match <= (final table == EXPECTED). The compare includes the bit written in the last SAMPLE, so compute it combinationally from the next-state table.
  - abcd returns to 0. Next state is IDLE.
- Timing: each vector occupies SETTLE+1 cycles, so a full scan is 16*(SETTLE+1) cycles. With SETTLE=1, start is sampled at edge 0 and done is high during the cycle after edge 32.
- start while busy or in DONE is ignored; no queuing.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE, busy drops, no done pulse.
  - table_out, ones and fail_valid keep their partial values; match stays 0.
  - abort has priority over a sample on the same edge: the bit is not captured.
  - abort in IDLE or DONE has no effect. start and abort together in IDLE means no scan starts.
- idx is a 4-bit counter and must not wrap: the idx==15 check precedes the increment.
- ones is 5 bits wide and reaches 16 without overflow.
- f_in is assumed stable at the sampling edge. The block adds no synchronizer, because the function block is on the same clock domain.

Test Plan:
1. Reset values: assert rstn=0 mid-run, asynchronously between edges -> all outputs 0 immediately; state IDLE after release.
2. Correct function model, SETTLE=1, pulse start -> abcd steps 0..15, each held 2 cycles; done pulses once, 32 cycles after start; table_out=16'h73F0, ones=9, match=1, fail_valid=0.
3. Faulty model with minterm 14 forced to 0 -> table_out=16'h33F0, ones=8, match=0, fail_valid=1, first_fail=14. Additionally force minterm 2 to 1 -> first_fail=2.
4. start re-pulsed at cycles 5 and 20 of a scan, and during DONE -> no restart; single done at cycle 32; results identical to scenario 2.
5. abort while abcd=5 in SETTLE -> busy=0 next cycle, no done; table_out bits 0..4 captured and higher bits 0; match=0. A fresh start then yields scenario 2's results.
6. SETTLE=3 -> each vector held 4 cycles, done at cycle 64, f_in sampled only in the fourth cycle of each vector. Verify by changing f_in glitchily during the first three cycles -> no effect on table_out.
